// File: rtl/sbox_share_checker_if.sv
// Stimulus/response share bus and result signals for the 2-share uBlock S-box checker.
interface sbox_share_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] n_vectors;
    logic             stim_valid;
    logic [3:0]       stim_s0;
    logic [3:0]       stim_s1;
    logic [3:0]       resp_s0;
    logic [3:0]       resp_s1;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [3:0]       first_err_in;
    logic [3:0]       first_err_got;

    modport master (
        output start, n_vectors, stim_valid, stim_s0, stim_s1, resp_s0, resp_s1,
        input  busy, done, pass, chk_cnt, err_cnt, first_err_vld, first_err_in, first_err_got
    );

    modport slave (
        input  start, n_vectors, stim_valid, stim_s0, stim_s1, resp_s0, resp_s1,
        output busy, done, pass, chk_cnt, err_cnt, first_err_vld, first_err_in, first_err_got
    );
endinterface

// File: rtl/sbox_share_checker.sv
// Recombines stimulus and response share pairs of the masked uBlock S-box and checks the
// unmasked response against the S-box table LATENCY cycles later; counts passes/failures.
module sbox_share_checker #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic                clk,
    input logic                rstn,
    sbox_share_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'h7;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'h9;  4'h3: sbox = 4'hC;
            4'h4: sbox = 4'hB;  4'h5: sbox = 4'hA;  4'h6: sbox = 4'hD;  4'h7: sbox = 4'h8;
            4'h8: sbox = 4'hF;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'h1;  4'hB: sbox = 4'h6;
            4'hC: sbox = 4'h0;  4'hD: sbox = 4'h3;  4'hE: sbox = 4'h2;  default: sbox = 4'h5;
        endcase
    endfunction

    state_t           state;
    logic [CNT_W-1:0] nvec;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             first_vld;
    logic [3:0]       first_in;
    logic [3:0]       first_got;
    logic             dl_vld [LATENCY];
    logic [3:0]       dl_x   [LATENCY];
    logic [3:0]       dl_exp [LATENCY];

    logic [3:0] stim_x;
    logic [3:0] resp_y;
    logic       issue;

    always_comb begin
        stim_x = bus.stim_s0 ^ bus.stim_s1;
        resp_y = bus.resp_s0 ^ bus.resp_s1;
        issue  = (state == RUN) && bus.stim_valid && (issued < nvec);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            nvec      <= '0;
            issued    <= '0;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            first_vld <= 1'b0;
            first_in  <= '0;
            first_got <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                dl_vld[i] <= 1'b0;
                dl_x[i]   <= '0;
                dl_exp[i] <= '0;
            end
        end else begin
            // Delay line only carries live entries while running; overridden below in RUN.
            for (int unsigned i = 0; i < LATENCY; i++) dl_vld[i] <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        nvec      <= bus.n_vectors;
                        issued    <= '0;
                        chk_cnt   <= '0;
                        err_cnt   <= '0;
                        first_vld <= 1'b0;
                        first_in  <= '0;
                        first_got <= '0;
                    end
                end
                RUN: begin
                    if (chk_cnt == nvec) begin
                        state <= DONE;
                    end else begin
                        for (int unsigned i = LATENCY - 1; i > 0; i--) begin
                            dl_vld[i] <= dl_vld[i-1];
                            dl_x[i]   <= dl_x[i-1];
                            dl_exp[i] <= dl_exp[i-1];
                        end
                        dl_vld[0] <= issue;
                        dl_x[0]   <= stim_x;
                        dl_exp[0] <= sbox(stim_x);
                        if (issue) issued <= issued + CNT_W'(1);
                        if (dl_vld[LATENCY-1]) begin
                            chk_cnt <= chk_cnt + CNT_W'(1);
                            if (resp_y != dl_exp[LATENCY-1]) begin
                                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                                if (!first_vld) begin
                                    first_vld <= 1'b1;
                                    first_in  <= dl_x[LATENCY-1];
                                    first_got <= resp_y;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state == RUN);
    assign bus.done          = (state == DONE);
    assign bus.pass          = (state == DONE) && (err_cnt == '0);
    assign bus.chk_cnt       = chk_cnt;
    assign bus.err_cnt       = err_cnt;
    assign bus.first_err_vld = first_vld;
    assign bus.first_err_in  = first_in;
    assign bus.first_err_got = first_got;
endmodule

// File: tb/tb_sbox_share_checker.sv
// Randomized scenario bench for sbox_share_checker with an ideal masked S-box response model.
module tb_sbox_share_checker;
    localparam int unsigned L = 2;
    localparam int unsigned W = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sbox_share_checker_if #(.CNT_W(W)) bus ();
    sbox_share_checker #(.LATENCY(L), .CNT_W(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [3:0] sb_tab [16] = '{4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
                                4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5};
    // Unmasked value the modelled shared S-box returns, L cycles after the stimulus.
    logic [3:0] pipe_y [L];
    logic [3:0] vx [$];
    logic [3:0] vf [$];

    typedef struct {
        logic [W-1:0] chk;
        logic [W-1:0] err;
        logic         fv;
        logic [3:0]   fin;
        logic [3:0]   fgot;
    } exp_t;

    // Expected outcome: only the first n vectors count; an error is any nonzero corruption.
    function automatic exp_t model(int unsigned n);
        exp_t e;
        e.chk = '0; e.err = '0; e.fv = 1'b0; e.fin = '0; e.fgot = '0;
        for (int unsigned i = 0; i < n && i < vx.size(); i++) begin
            e.chk = e.chk + W'(1);
            if (vf[i] != 4'h0) begin
                e.err = e.err + W'(1);
                if (!e.fv) begin
                    e.fv   = 1'b1;
                    e.fin  = vx[i];
                    e.fgot = sb_tab[vx[i]] ^ vf[i];
                end
            end
        end
        return e;
    endfunction

    task automatic step(input bit st, input logic [W-1:0] n, input bit v,
                        input logic [3:0] x, input logic [3:0] flip);
        logic [3:0] m, r;
        @(negedge clk);
        m = 4'($urandom);
        r = 4'($urandom);
        bus.start      = st;
        bus.n_vectors  = n;
        bus.stim_valid = v;
        bus.stim_s0    = m;
        bus.stim_s1    = m ^ x;
        bus.resp_s0    = r;
        bus.resp_s1    = r ^ pipe_y[L-1];
        for (int i = L - 1; i > 0; i--) pipe_y[i] = pipe_y[i-1];
        pipe_y[0] = sb_tab[x] ^ flip;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 4'($urandom), 4'h0);
    endtask

    task automatic issue_all(input bit gaps);
        for (int i = 0; i < vx.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle();
            step(1'b0, '0, 1'b1, vx[i], vf[i]);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bus.done && k < 20) begin
            idle();
            k++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            $display("FAIL %s_done_timeout: done=%b required 1", tag, bus.done);
            errors++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.n_vectors = '0; bus.stim_valid = 1'b0;
        bus.stim_s0 = '0; bus.stim_s1 = '0; bus.resp_s0 = '0; bus.resp_s1 = '0;
        for (int i = 0; i < L; i++) pipe_y[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.chk_cnt, bus.err_cnt, bus.first_err_vld,
             bus.first_err_in, bus.first_err_got} !== '0) begin
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b chk=%0d err=%0d fv=%b required all 0",
                     bus.busy, bus.done, bus.pass, bus.chk_cnt, bus.err_cnt, bus.first_err_vld);
            errors++;
        end
        rstn = 1'b1;
    endtask

    task automatic test_ideal();
        exp_t e;
        vx.delete(); vf.delete();
        for (int i = 0; i < 16; i++) begin vx.push_back(4'(i)); vf.push_back(4'h0); end
        step(1'b1, W'(16), 1'b0, 4'h0, 4'h0);
        issue_all(1'b1);
        e = model(16);
        wait_done("ideal");
        checks++;
        if (bus.pass !== 1'b1) begin $display("FAIL ideal_pass: got %b required 1", bus.pass); errors++; end
        checks++;
        if (bus.chk_cnt !== e.chk) begin $display("FAIL ideal_chk: got %0d required %0d", bus.chk_cnt, e.chk); errors++; end
        checks++;
        if (bus.err_cnt !== e.err) begin $display("FAIL ideal_err: got %0d required %0d", bus.err_cnt, e.err); errors++; end
        checks++;
        if (bus.busy !== 1'b0 || bus.first_err_vld !== 1'b0) begin
            $display("FAIL ideal_flags: busy=%b fv=%b required 0 0", bus.busy, bus.first_err_vld); errors++;
        end
    endtask

    task automatic test_error();
        exp_t e;
        vx.delete(); vf.delete();
        for (int i = 0; i < 16; i++) begin vx.push_back(4'(i)); vf.push_back(4'h0); end
        vf[5]  = 4'h1;
        vf[12] = 4'h6;
        step(1'b1, W'(16), 1'b0, 4'h0, 4'h0);
        issue_all(1'b0);
        e = model(16);
        wait_done("error");
        checks++;
        if (bus.err_cnt !== e.err) begin $display("FAIL error_err: got %0d required %0d", bus.err_cnt, e.err); errors++; end
        checks++;
        if (bus.first_err_vld !== 1'b1 || bus.first_err_in !== e.fin) begin
            $display("FAIL error_first_in: vld=%b in=%h required 1 %h", bus.first_err_vld, bus.first_err_in, e.fin); errors++;
        end
        checks++;
        if (bus.first_err_got !== e.fgot) begin
            $display("FAIL error_first_got: got %h required %h", bus.first_err_got, e.fgot); errors++;
        end
        checks++;
        if (bus.pass !== 1'b0 || bus.chk_cnt !== e.chk) begin
            $display("FAIL error_pass_chk: pass=%b chk=%0d required 0 %0d", bus.pass, bus.chk_cnt, e.chk); errors++;
        end
    endtask

    task automatic test_restart();
        exp_t e;
        int unsigned n = $urandom_range(3, 10);
        vx.delete(); vf.delete();
        for (int unsigned i = 0; i < n; i++) begin
            vx.push_back(4'($urandom));
            vf.push_back(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
        end
        step(1'b1, W'(n), 1'b0, 4'h0, 4'h0);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.first_err_vld !== 1'b0 ||
            bus.chk_cnt !== '0 || bus.err_cnt !== '0) begin
            $display("FAIL restart_clear: busy=%b done=%b fv=%b chk=%0d err=%0d required 1 0 0 0 0",
                     bus.busy, bus.done, bus.first_err_vld, bus.chk_cnt, bus.err_cnt); errors++;
        end
        issue_all(1'b1);
        e = model(n);
        wait_done("restart");
        checks++;
        if (bus.chk_cnt !== e.chk || bus.err_cnt !== e.err) begin
            $display("FAIL restart_counts: chk=%0d err=%0d required %0d %0d", bus.chk_cnt, bus.err_cnt, e.chk, e.err); errors++;
        end
        checks++;
        if (bus.first_err_vld !== e.fv || bus.first_err_in !== e.fin || bus.first_err_got !== e.fgot) begin
            $display("FAIL restart_first: vld=%b in=%h got=%h required %b %h %h", bus.first_err_vld,
                     bus.first_err_in, bus.first_err_got, e.fv, e.fin, e.fgot); errors++;
        end
        checks++;
        if (bus.pass !== (e.err == '0)) begin
            $display("FAIL restart_pass: got %b required %b", bus.pass, (e.err == '0)); errors++;
        end
    endtask

    task automatic test_zero();
        step(1'b1, '0, 1'b0, 4'h0, 4'h0);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            $display("FAIL zero_busy: busy=%b done=%b required 1 0", bus.busy, bus.done); errors++;
        end
        idle();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.chk_cnt !== '0) begin
            $display("FAIL zero_done: busy=%b done=%b pass=%b chk=%0d required 0 1 1 0",
                     bus.busy, bus.done, bus.pass, bus.chk_cnt); errors++;
        end
    endtask

    task automatic test_idle_pulses();
        exp_t e;
        pulse_reset();
        repeat (3) step(1'b0, '0, 1'b1, 4'($urandom), 4'h3);
        vx.delete(); vf.delete();
        for (int i = 0; i < 6; i++) begin vx.push_back(4'($urandom)); vf.push_back(4'h0); end
        vf[2] = 4'h4;
        vf[4] = 4'h9;
        vf[5] = 4'hF;
        // Stimulus on the start edge itself is not yet in RUN and must be ignored.
        step(1'b1, W'(4), 1'b1, 4'($urandom), 4'h5);
        step(1'b0, '0, 1'b1, vx[0], vf[0]);
        step(1'b1, W'(99), 1'b1, vx[1], vf[1]);
        for (int i = 2; i < 6; i++) step(1'b0, '0, 1'b1, vx[i], vf[i]);
        e = model(4);
        wait_done("idle_pulses");
        checks++;
        if (bus.chk_cnt !== e.chk || bus.err_cnt !== e.err) begin
            $display("FAIL idle_pulses_counts: chk=%0d err=%0d required %0d %0d",
                     bus.chk_cnt, bus.err_cnt, e.chk, e.err); errors++;
        end
        checks++;
        if (bus.first_err_in !== e.fin || bus.first_err_got !== e.fgot) begin
            $display("FAIL idle_pulses_first: in=%h got=%h required %h %h",
                     bus.first_err_in, bus.first_err_got, e.fin, e.fgot); errors++;
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int i = 0;
        vx.delete(); vf.delete();
        for (int k = 0; k < 8; k++) begin vx.push_back(4'($urandom)); vf.push_back(4'h0); end
        step(1'b1, W'(8), 1'b0, 4'h0, 4'h0);
        while (bus.chk_cnt !== W'(3) && i < 8) begin
            step(1'b0, '0, 1'b1, vx[i], vf[i]);
            i++;
        end
        checks++;
        if (bus.chk_cnt !== W'(3)) begin
            $display("FAIL midrun_reach3: chk=%0d required 3", bus.chk_cnt); errors++;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.chk_cnt, bus.err_cnt, bus.first_err_vld,
             bus.first_err_in, bus.first_err_got} !== '0) begin
            $display("FAIL midrun_reset_outputs: busy=%b done=%b chk=%0d err=%0d required all 0",
                     bus.busy, bus.done, bus.chk_cnt, bus.err_cnt); errors++;
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.chk_cnt !== '0) begin
            $display("FAIL midrun_idle: busy=%b done=%b chk=%0d required 0 0 0",
                     bus.busy, bus.done, bus.chk_cnt); errors++;
        end
        step(1'b1, W'(8), 1'b0, 4'h0, 4'h0);
        issue_all(1'b1);
        e = model(8);
        wait_done("midrun_rerun");
        checks++;
        if (bus.pass !== 1'b1 || bus.chk_cnt !== e.chk) begin
            $display("FAIL midrun_rerun: pass=%b chk=%0d required 1 %0d", bus.pass, bus.chk_cnt, e.chk); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_error();
        test_restart();
        test_zero();
        test_idle_pulses();
        test_reset_midrun();
        for (int r = 0; r < 3; r++) test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
